// File: rtl/serial_mod5_tx.sv
// Parallel-to-serial transmitter for the serial divisible-by-5 checker.
// Shifts each accepted word out MSB first and tracks the expected checker output.
module serial_mod5_tx #(
    parameter int WIDTH       = 8,
    parameter int IDLE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             rx_clr_n,
    output logic             exp_div5,
    output logic             word_done,
    output logic             word_div5
);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, GAP} state_t;

    localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [3:0]    GAP_LAST = (IDLE_CYCLES > 0) ? 4'(IDLE_CYCLES - 1) : 4'd0;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [IW-1:0]    r_idx;
    logic [3:0]       r_gap;
    logic [2:0]       r_residue;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_dout_last;
    logic             r_rx_clr_n;
    logic             r_word_done;
    logic             r_word_div5;

    logic [2:0]       w_res_safe;
    logic [3:0]       w_sum;
    logic [2:0]       w_res_next;

    // Out-of-range residues (5..7) are treated as 0 before doubling.
    assign w_res_safe = (r_residue > 3'd4) ? 3'd0 : r_residue;
    assign w_sum      = {w_res_safe, 1'b0} + {3'b000, r_dout};
    assign w_res_next = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];

    assign s_ready    = (r_state == IDLE);
    assign exp_div5   = (w_res_safe == 3'd0);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign rx_clr_n   = r_rx_clr_n;
    assign word_done  = r_word_done;
    assign word_div5  = r_word_div5;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_residue    <= 3'd0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_rx_clr_n   <= 1'b1;
            r_word_done  <= 1'b0;
            r_word_div5  <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_word_div5 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_shift    <= s_data;
                        r_rx_clr_n <= 1'b0;
                        r_residue  <= 3'd0;
                        r_state    <= CLR;
                    end
                end
                CLR: begin
                    r_rx_clr_n   <= 1'b1;
                    r_dout       <= r_shift[WIDTH-1];
                    r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
                    r_dout_valid <= 1'b1;
                    r_dout_last  <= 1'b0;
                    r_idx        <= IDX_TOP;
                    r_state      <= SHIFT;
                end
                SHIFT: begin
                    // The residue absorbs the bit currently on dout at the end of its cycle.
                    r_residue <= w_res_next;
                    if (r_idx == '0) begin
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        r_word_done  <= 1'b1;
                        r_word_div5  <= (w_res_next == 3'd0);
                        r_gap        <= '0;
                        r_state      <= (IDLE_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        r_idx       <= r_idx - IDX_ONE;
                        r_dout      <= r_shift[WIDTH-1];
                        r_shift     <= {r_shift[WIDTH-2:0], 1'b0};
                        r_dout_last <= (r_idx == IDX_ONE);
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mod5_tx.sv
// Bench for serial_mod5_tx: an 8-bit instance with no gap and a 16-bit instance with a
// 3-cycle gap, each feeding a behavioural divisible-by-5 checker.
module tb_serial_mod5_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stimValid = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] stimData = '0;

    int vectors = 0;
    int miscompares = 0;

    logic aValid, aReady, aDout, aDoutValid, aDoutLast, aRxClrN, aExp, aWordDone, aWordDiv5;
    logic bValid, bReady, bDout, bDoutValid, bDoutLast, bRxClrN, bExp, bWordDone, bWordDiv5;
    logic oReady, oDout, oDoutValid, oDoutLast, oRxClrN, oExp, oWordDone, oWordDiv5;
    logic chkDout;
    int   chkA, chkB;

    always #5 clk = ~clk;

    assign aValid = stimValid & ~sel;
    assign bValid = stimValid & sel;

    serial_mod5_tx #(.WIDTH(8), .IDLE_CYCLES(0)) dutA (
        .clk(clk), .resetn(resetn), .s_valid(aValid), .s_ready(aReady),
        .s_data(stimData[7:0]), .dout(aDout), .dout_valid(aDoutValid),
        .dout_last(aDoutLast), .rx_clr_n(aRxClrN), .exp_div5(aExp),
        .word_done(aWordDone), .word_div5(aWordDiv5)
    );

    serial_mod5_tx #(.WIDTH(16), .IDLE_CYCLES(3)) dutB (
        .clk(clk), .resetn(resetn), .s_valid(bValid), .s_ready(bReady),
        .s_data(stimData), .dout(bDout), .dout_valid(bDoutValid),
        .dout_last(bDoutLast), .rx_clr_n(bRxClrN), .exp_div5(bExp),
        .word_done(bWordDone), .word_div5(bWordDiv5)
    );

    assign oReady     = sel ? bReady     : aReady;
    assign oDout      = sel ? bDout      : aDout;
    assign oDoutValid = sel ? bDoutValid : aDoutValid;
    assign oDoutLast  = sel ? bDoutLast  : aDoutLast;
    assign oRxClrN    = sel ? bRxClrN    : aRxClrN;
    assign oExp       = sel ? bExp       : aExp;
    assign oWordDone  = sel ? bWordDone  : aWordDone;
    assign oWordDiv5  = sel ? bWordDiv5  : aWordDiv5;

    // Behavioural downstream checkers: residue of the bits received since the last clear.
    always @(posedge clk or negedge aRxClrN) begin
        if (!aRxClrN) chkA <= 0;
        else          chkA <= (chkA * 2 + (aDout ? 1 : 0)) % 5;
    end

    always @(posedge clk or negedge bRxClrN) begin
        if (!bRxClrN) chkB <= 0;
        else          chkB <= (chkB * 2 + (bDout ? 1 : 0)) % 5;
    end

    assign chkDout = sel ? (chkB == 0) : (chkA == 0);

    // Global guard so a stuck run still ends with a report.
    initial begin
        #5000000;
        $display("[TB] FAIL globalTimeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady();
        for (int i = 0; i < 50 && oReady !== 1'b1; i++) @(negedge clk);
        checkOutput("readyWait", oReady, 1);
    endtask

    // Sends one word on the selected instance and checks every cycle from CLR through
    // word_done (plus the gap). With chain set, s_valid stays high carrying nextWord so it
    // is taken in the word_done cycle; the following call then uses skipStart.
    task automatic applyStimulus(input logic [15:0] word, input bit chain,
                                 input logic [15:0] nextWord, input bit skipStart);
        int w, ic, pv;
        logic expBit, expDiv;
        w  = sel ? 16 : 8;
        ic = sel ? 3 : 0;
        if (!skipStart) begin
            waitReady();
            stimData  = word;
            stimValid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        if (chain) stimData = nextWord;
        else       stimValid = 1'b0;
        checkOutput("clrLow",     oRxClrN, 0);
        checkOutput("clrValid",   oDoutValid, 0);
        checkOutput("clrDout",    oDout, 0);
        checkOutput("clrReady",   oReady, 0);
        checkOutput("clrExp",     oExp, 1);
        checkOutput("clrChecker", chkDout, oExp);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            pv     = int'(word) >> (w - k);
            expBit = word[w-1-k];
            checkOutput("shiftDout",    oDout, expBit);
            checkOutput("shiftValid",   oDoutValid, 1);
            checkOutput("shiftLast",    oDoutLast, (k == w - 1));
            checkOutput("shiftClr",     oRxClrN, 1);
            checkOutput("shiftReady",   oReady, 0);
            checkOutput("shiftDone",    oWordDone, 0);
            checkOutput("shiftExp",     oExp, (pv % 5 == 0));
            checkOutput("shiftChecker", chkDout, oExp);
        end
        @(negedge clk);
        expDiv = (int'(word) % 5 == 0);
        checkOutput("doneFlag",    oWordDone, 1);
        checkOutput("doneDiv5",    oWordDiv5, expDiv);
        checkOutput("doneValid",   oDoutValid, 0);
        checkOutput("doneLast",    oDoutLast, 0);
        checkOutput("doneExp",     oExp, expDiv);
        checkOutput("doneChecker", chkDout, oExp);
        checkOutput("doneReady",   oReady, (ic == 0));
        if (chain) begin
            @(posedge clk);
        end else begin
            for (int g = 1; g <= ic; g++) begin
                @(negedge clk);
                checkOutput("gapReady", oReady, (g == ic));
                checkOutput("gapValid", oDoutValid, 0);
                checkOutput("gapDout",  oDout, 0);
                checkOutput("gapDone",  oWordDone, 0);
                checkOutput("gapDiv5",  oWordDiv5, 0);
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Ready"}, oReady, 1);
        checkOutput({tag, "Dout"},  oDout, 0);
        checkOutput({tag, "Valid"}, oDoutValid, 0);
        checkOutput({tag, "Last"},  oDoutLast, 0);
        checkOutput({tag, "ClrN"},  oRxClrN, 1);
        checkOutput({tag, "Exp"},   oExp, 1);
        checkOutput({tag, "Done"},  oWordDone, 0);
        checkOutput({tag, "Div5"},  oWordDiv5, 0);
    endtask

    initial begin
        logic [15:0] cur, nxt;
        bit chainNow, skipNow;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        sel = 1'b0; #1 checkResetOutputs("rstA");
        sel = 1'b1; #1 checkResetOutputs("rstB");
        @(negedge clk);
        resetn = 1'b1;
        sel = 1'b0;
        @(negedge clk);

        $display("[TB] directed 8-bit words");
        applyStimulus(16'h000A, 1'b0, 16'h0000, 1'b0);
        applyStimulus(16'h0007, 1'b0, 16'h0000, 1'b0);
        applyStimulus(16'h00FF, 1'b0, 16'h0000, 1'b0);
        applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("[TB] back-to-back words with s_valid held");
        applyStimulus(16'h003C, 1'b1, 16'h00C3, 1'b0);
        applyStimulus(16'h00C3, 1'b0, 16'h0000, 1'b1);

        $display("[TB] reset in the middle of a word");
        waitReady();
        stimData  = 16'h00A5;
        stimValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stimValid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("preResetValid", oDoutValid, 1);
        checkOutput("preResetDout",  oDout, 0);
        #2 resetn = 1'b0;
        #1 checkResetOutputs("midRst");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("postResetDone",  oWordDone, 0);
            checkOutput("postResetValid", oDoutValid, 0);
        end
        applyStimulus(16'h0005, 1'b0, 16'h0000, 1'b0);

        $display("[TB] 16-bit instance with idle gap");
        sel = 1'b1;
        @(negedge clk);
        applyStimulus(16'hBEEF, 1'b0, 16'h0000, 1'b0);
        applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("[TB] random words, 8-bit");
        sel = 1'b0;
        @(negedge clk);
        cur = 16'($urandom_range(0, 255));
        skipNow = 1'b0;
        for (int i = 0; i < 500; i++) begin
            nxt = 16'($urandom_range(0, 255));
            chainNow = (i < 499) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(cur, chainNow, nxt, skipNow);
            skipNow = chainNow;
            cur = nxt;
        end

        $display("[TB] random words, 16-bit");
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            cur = 16'($urandom_range(0, 65535));
            applyStimulus(cur, 1'b0, 16'h0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_mod5_tx.md
Name: serial_mod5_tx

Overview:
- Parallel-to-serial transmitter feeding the team's serial divisible-by-5 checker.
- Accepts a WIDTH-bit word on a valid/ready handshake, pulses the checker's history clear, then shifts the word out MSB first, one bit per clock.
- Tracks the running mod-5 residue of the emitted bits and presents the checker's expected output for cycle-by-cycle comparison on the bench or in-system self-check.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- IDLE_CYCLES, 0, idle cycles inserted after each word before s_ready reasserts (0..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word.
- s_data  input  WIDTH  word to transmit, unsigned.
- dout  output  1  serial bit to checker din, MSB first.
- dout_valid  output  1  dout carries a data bit this cycle.
- dout_last  output  1  current bit is the LSB.
- rx_clr_n  output  1  active-low history clear for the checker, one cycle per word.
- exp_div5  output  1  expected checker dout this cycle.
- word_done  output  1  one-cycle pulse after the last bit.
- word_div5  output  1  full word mod 5 == 0; valid only with word_done.

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - state IDLE, s_ready=1, dout=0, dout_valid=0, dout_last=0, rx_clr_n=1.
  - residue=0, exp_div5=1, word_done=0, word_div5=0.
- All outputs are registered, except s_ready, which is decoded from state, and exp_div5, which is decoded from the residue register.
- Handshake:
  - Transfer occurs on a rising edge with s_valid && s_ready.
  - s_data is captured into the shift register on that edge.
  - s_ready=1 only in IDLE. s_data is ignored in all other states.
- State machine: IDLE, CLR, SHIFT, GAP.
  - IDLE: on transfer go to CLR. Otherwise stay.
  - CLR (1 cycle): rx_clr_n=0, dout_valid=0, dout=0, residue cleared to 0. Next state SHIFT with bit index WIDTH-1.
  - SHIFT (WIDTH cycles): dout=word[idx], dout_valid=1, dout_last=(idx==0). Each edge: residue <= (2*residue + dout) mod 5, idx decrements.
    - After idx==0: if IDLE_CYCLES==0 go to IDLE, else go to GAP.
  - GAP: dout_valid=0, dout=0. Count IDLE_CYCLES cycles, then go to IDLE.
- Latency: transfer at edge T gives CLR in cycle T+1 and the MSB in cycle T+2. LSB is in cycle T+1+WIDTH. word_done is high in cycle T+2+WIDTH.
- Throughput: one word per WIDTH+2+IDLE_CYCLES cycles. Back-to-back upstream s_valid is accepted in the first IDLE cycle.
- exp_div5 = (residue==0). The residue covers the bits emitted in earlier SHIFT cycles of the current word. This equals the checker's dout in the same cycle when the checker's din is driven by dout. It is meaningful from CLR through the cycle of word_done.
- word_done / word_div5:
  - word_done pulses exactly one cycle, the cycle after the LSB.
  - word_div5 = (final residue==0), i.e. s_data mod 5 == 0.
  - Both are 0 at all other times.
- residue is 3 bits, values 0..4 only. Values 5..7 are unreachable and must map to 0 if they occur.
- Reset asserted mid-word: the word is abandoned, all outputs return to reset values immediately, and no word_done is issued. After release, the block is in IDLE.
- s_valid deasserting while not ready has no effect. No word is lost or duplicated.

Test Plan:
- Reset, then s_data=8'h0A accepted at T.
  - -> rx_clr_n=0 at T+1.
  - -> dout sequence 0,0,0,0,1,0,1,0 over T+2..T+9, with dout_last only at T+9.
  - -> exp_div5 1,1,1,1,1,0,0,1.
  - -> word_done=1 and word_div5=1 at T+10.
- s_data=8'h07 -> word_div5=0. s_data=8'hFF (255) -> word_div5=1. s_data=8'h00 -> exp_div5 stays 1 for the whole word, word_div5=1.
- s_valid held high with two words, IDLE_CYCLES=0 -> s_ready=0 during CLR/SHIFT, second transfer in the cycle word_done is high, 10-cycle spacing, and the second word is not corrupted.
- IDLE_CYCLES=3 -> s_ready returns 3 cycles after word_done, and dout_valid=0 throughout GAP.
- resetn pulsed low mid-SHIFT (after 4 bits of 8'hA5) -> outputs reach reset values without waiting for a clock edge, and no word_done. Next word 8'h05 transmits correctly with word_div5=1.
- Self-check loop (checker din=dout, checker reset = rx_clr_n) over 500 random words, WIDTH=8 and 16 -> checker dout == exp_div5 on every cycle from CLR through word_done.
